// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receiver front end: 8N1 (or 8E1) deserializer with valid/ready byte output
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing, adds parity_error output).
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_serial      asynchronous serial line, idle high
//   rx_enable      receiver enable; low aborts any frame in progress
//   rx_ready       consumer accepts the held byte when high with rx_valid
//   rx_data_out    received byte, stable while rx_valid is high
//   rx_valid       byte available in the holding register
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun_error  one-cycle pulse: good byte dropped, holding register full
//   parity_error   one-cycle pulse: even-parity mismatch (UART_RX_PARITY_EN only)
//   busy           high whenever the receive FSM is not idle
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic       rx_enable,
  input  logic       rx_ready,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             sync1;
  logic             sync2;
  logic             prev_s;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  assign rx_s = sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      prev_s        <= 1'b1;
      rx_data_out   <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
      par_bad       <= 1'b0;
`endif
    end else begin
      sync1         <= rx_serial;
      sync2         <= sync1;
      prev_s        <= rx_s;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif

      // Handshake clear; a byte delivered in the same cycle overrides this below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state != IDLE && !rx_enable) begin
        // Abort: drop the partial frame silently, holding register untouched.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Require a real 1->0 edge so a held-low line (break) cannot re-trigger.
            if (rx_enable && prev_s && !rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end

          START: begin
            if (cnt == CNT_HALF) begin
              cnt   <= '0;
              idx   <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[7:1]};
              if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              // Even parity: data bits plus parity bit must hold an even count of ones.
              par_bad <= ^{shreg, rx_s};
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (cnt == CNT_LAST) begin
              // Sample mid stop bit and leave at once so the next start edge is not missed.
              cnt   <= '0;
              state <= IDLE;
              if (!rx_s) begin
                framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_error <= 1'b1;
`endif
              end else if (!rx_valid || rx_ready) begin
                rx_data_out <= shreg;
                rx_valid    <= 1'b1;
              end else begin
                overrun_error <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - scoreboard testbench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;
  int pe_cnt = 0;
  int exp_fe = 0;
  int exp_oe = 0;
  int exp_pe = 0;
  logic [7:0] exp_q[$];

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_serial(rx_serial),
    .rx_enable(rx_enable),
    .rx_ready(rx_ready),
    .rx_data_out(rx_data_out),
    .rx_valid(rx_valid),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    chk("busy_in_frame", int'(busy), 1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop);
    rx_serial = 1'b1;
    tick(4);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_framing"}, fe_cnt, exp_fe);
    chk({name, "_overrun"}, oe_cnt, exp_oe);
`ifdef UART_RX_PARITY_EN
    chk({name, "_parity"}, pe_cnt, exp_pe);
`endif
  endtask

  // Monitor: pops the scoreboard on every handshake and counts error pulses.
  logic       pv = 1'b0;
  logic       phs = 1'b0;
  logic [7:0] pdata = '0;
  always begin
    @(negedge clk);
    if (rst_n) begin
      logic pe_now;
      pe_now = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_now = parity_error;
`endif
      if (framing_error) fe_cnt++;
      if (overrun_error) oe_cnt++;
      if (pe_now) pe_cnt++;
      if (framing_error || overrun_error || pe_now)
        chk("err_exclusive", int'(framing_error) + int'(overrun_error) + int'(pe_now), 1);
      if (pv && !phs && rx_valid)
        chk("data_stable", int'(rx_data_out), int'(pdata));
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rx_data", int'(rx_data_out), int'(e));
        end
      end
      pv    = rx_valid;
      phs   = rx_valid && rx_ready;
      pdata = rx_data_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_framing", int'(framing_error), 0);
    chk("reset_overrun", int'(overrun_error), 0);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    tick(5);

    // Plain byte with consumer ready.
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_valid_cleared", int'(rx_valid), 0);
    chk("a5_idle", int'(busy), 0);
    chk_counts("a5");

    // Overrun: hold 0x3C, drop 0xFF.
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("3c_valid", int'(rx_valid), 1);
    chk("3c_data", int'(rx_data_out), 8'h3C);
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_oe++;
    chk("ff_kept_data", int'(rx_data_out), 8'h3C);
    chk_counts("ff_overrun");
    rx_ready = 1'b1;
    tick(1);
    chk("3c_valid_dropped", int'(rx_valid), 0);

    // Framing error, then a good frame.
    send_frame(8'h81, 1'b0, 1'b0);
    exp_fe++;
    chk("81_no_valid", int'(rx_valid), 0);
    chk_counts("81_framing");
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    chk_counts("42");

    // Short glitch: false start.
    rx_serial = 1'b0;
    tick(3);
    rx_serial = 1'b1;
    tick(CPB * 2);
    chk("glitch_idle", int'(busy), 0);
    chk("glitch_no_valid", int'(rx_valid), 0);
    chk_counts("glitch");

    // Enable drop mid-frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(8'h55 >> i);
    rx_enable = 1'b0;
    tick(1);
    chk("abort_busy", int'(busy), 0);
    rx_serial = 1'b1;
    tick(4);
    rx_enable = 1'b1;
    tick(4);
    chk("abort_no_valid", int'(rx_valid), 0);
    chk_counts("abort");
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    chk_counts("55");

    // Break: line low far beyond a frame, no re-trigger while low.
    rx_serial = 1'b0;
    tick(CPB * 12);
    exp_fe++;
    chk("break_idle", int'(busy), 0);
    tick(CPB * 2);
    chk("break_still_idle", int'(busy), 0);
    chk("break_no_valid", int'(rx_valid), 0);
    chk_counts("break");
    rx_serial = 1'b1;
    tick(4);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    exp_pe++;
    chk("07_bad_parity_no_valid", int'(rx_valid), 0);
    chk_counts("07_parity");
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    chk_counts("07_good");
`endif

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk_counts("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
